// File: rtl/sys_bus_arbiter.sv
// Two-master, three-slave system bus arbiter: round-robin grant, address
// decode on adr[31:28], per-transfer timeout, fully registered outputs.
module sys_bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [2:0]  s_sel,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_wdata,
    input  logic [2:0]  s_ack,
    input  logic [95:0] s_rdata,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter value seen in the last ACCESS cycle allowed before abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        prio_m1_r;
    logic        any_req_s;
    logic        win_m1_s;
    logic        win_we_s;
    logic [31:0] win_adr_s;
    logic [31:0] win_wdata_s;
    logic [2:0]  win_sel_s;
    logic        ack_hit_s;
    logic [31:0] sel_rdata_s;
    logic [31:0] done_rdata_s;

    function automatic logic [2:0] slave_decode(input logic [3:0] field);
        case (field)
            4'h1:    slave_decode = 3'b001;
            4'h2:    slave_decode = 3'b010;
            4'h3:    slave_decode = 3'b100;
            default: slave_decode = 3'b000;
        endcase
    endfunction

    // Arbitration: a lone requester wins; on contention the master not granted last wins.
    always_comb begin
        any_req_s   = m0_req | m1_req;
        win_m1_s    = 1'b0;
        win_we_s    = 1'b0;
        win_adr_s   = 32'h0000_0000;
        win_wdata_s = 32'h0000_0000;
        if (m0_req && m1_req) begin
            win_m1_s = prio_m1_r;
        end else begin
            win_m1_s = m1_req;
        end
        if (win_m1_s) begin
            win_we_s    = m1_we;
            win_adr_s   = m1_adr;
            win_wdata_s = m1_wdata;
        end else begin
            win_we_s    = m0_we;
            win_adr_s   = m0_adr;
            win_wdata_s = m0_wdata;
        end
        win_sel_s = slave_decode(win_adr_s[31:28]);
    end

    // Slave return path: only the selected slave's ack and data slice count.
    always_comb begin
        ack_hit_s   = |(s_ack & s_sel);
        sel_rdata_s = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            if (s_sel[i]) begin
                sel_rdata_s = sel_rdata_s | s_rdata[32*i +: 32];
            end else begin
                sel_rdata_s = sel_rdata_s;
            end
        end
        if (ack_hit_s) begin
            done_rdata_s = sel_rdata_s;
        end else begin
            done_rdata_s = 32'h0000_0000;
        end
    end

    // Transfer FSM with all bus outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            prio_m1_r <= 1'b0;
            grant     <= 2'b00;
            s_sel     <= 3'b000;
            s_we      <= 1'b0;
            s_adr     <= 32'h0000_0000;
            s_wdata   <= 32'h0000_0000;
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= 32'h0000_0000;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant     <= win_m1_s ? 2'b10 : 2'b01;
                        prio_m1_r <= ~win_m1_s;
                        cnt_r     <= 8'd0;
                        if (win_sel_s != 3'b000) begin
                            state_r <= ST_ACCESS;
                            s_sel   <= win_sel_s;
                            s_we    <= win_we_s;
                            s_adr   <= win_adr_s;
                            s_wdata <= win_wdata_s;
                        end else begin
                            // Unmapped slave: answer with an error, never touch the bus.
                            state_r <= ST_DONE;
                            m0_ack  <= ~win_m1_s;
                            m0_err  <= ~win_m1_s;
                            m1_ack  <= win_m1_s;
                            m1_err  <= win_m1_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (ack_hit_s || (cnt_r == CNT_LAST)) begin
                        state_r  <= ST_DONE;
                        s_sel    <= 3'b000;
                        s_we     <= 1'b0;
                        s_adr    <= 32'h0000_0000;
                        s_wdata  <= 32'h0000_0000;
                        m0_ack   <= grant[0];
                        m0_err   <= grant[0] & ~ack_hit_s;
                        m0_rdata <= grant[0] ? done_rdata_s : 32'h0000_0000;
                        m1_ack   <= grant[1];
                        m1_err   <= grant[1] & ~ack_hit_s;
                        m1_rdata <= grant[1] ? done_rdata_s : 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= 8'd0;
                    grant    <= 2'b00;
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m0_rdata <= 32'h0000_0000;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    m1_rdata <= 32'h0000_0000;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= 8'd0;
                    grant    <= 2'b00;
                    s_sel    <= 3'b000;
                    s_we     <= 1'b0;
                    s_adr    <= 32'h0000_0000;
                    s_wdata  <= 32'h0000_0000;
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m0_rdata <= 32'h0000_0000;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    m1_rdata <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: directed vector table, reset
// corner sequence and random transfers against a transaction-level model.
module tb_sys_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_adr = 32'h0, m0_wdata = 32'h0, m1_adr = 32'h0, m1_wdata = 32'h0;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_we;
    logic [31:0] m0_rdata, m1_rdata, s_adr, s_wdata;
    logic [2:0]  s_sel;
    logic [2:0]  s_ack = 3'b000;
    logic [95:0] s_rdata = 96'h0;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    sys_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_sel(s_sel), .s_we(s_we), .s_adr(s_adr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant)
    );

    typedef struct {
        bit          m0_req;
        bit          m1_req;
        logic [31:0] m0_adr;
        logic [31:0] m1_adr;
        bit          we;
        logic [31:0] wdata;
        int          ack_at;   // ACCESS cycle (1-based) in which the slave acks; 0 = never
        bit          spur;     // pulse unselected slave acks while waiting
        logic [31:0] rdata;
        bit          exp_m1;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_prio_m1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r0, bit r1, logic [31:0] a0, logic [31:0] a1, bit we,
                                logic [31:0] wd, int ack_at, bit spur, logic [31:0] rd,
                                bit e_m1, int e_lat, bit e_err, logic [31:0] e_rd);
        vec_t v;
        v.m0_req = r0; v.m1_req = r1; v.m0_adr = a0; v.m1_adr = a1; v.we = we;
        v.wdata = wd; v.ack_at = ack_at; v.spur = spur; v.rdata = rd;
        v.exp_m1 = e_m1; v.exp_lat = e_lat; v.exp_err = e_err; v.exp_rdata = e_rd;
        return v;
    endfunction

    // Transaction-level reference: who wins, how many cycles, what comes back.
    task automatic model(input vec_t v, output bit m1w, output int lat, output bit err,
                         output logic [31:0] rd);
        logic [3:0] field;
        if (v.m0_req && v.m1_req) m1w = model_prio_m1;
        else m1w = v.m1_req;
        model_prio_m1 = !m1w;
        field = m1w ? v.m1_adr[31:28] : v.m0_adr[31:28];
        if (field >= 4'd1 && field <= 4'd3) begin
            if (v.ack_at >= 1 && v.ack_at <= TO) begin
                lat = v.ack_at + 1; err = 1'b0; rd = v.rdata;
            end else begin
                lat = TO + 1; err = 1'b1; rd = 32'h0;
            end
        end else begin
            lat = 1; err = 1'b1; rd = 32'h0;
        end
    endtask

    // Drives one transfer from an IDLE cycle and returns on the following IDLE cycle.
    task automatic run_txn(input vec_t v, input bit exp_m1, output bit got_m1, output int lat,
                           output bit err, output logic [31:0] rd, output logic [1:0] gnt1,
                           output bit bad);
        int cyc, acc;
        bit done;
        logic [31:0] eadr, ewd, rdv;
        logic [3:0]  field;
        logic [2:0]  esel;
        got_m1 = 1'b0; lat = -1; err = 1'b0; rd = 32'h0; gnt1 = 2'b00; bad = 1'b0;
        m0_req = v.m0_req; m0_we = v.we; m0_adr = v.m0_adr; m0_wdata = v.wdata;
        m1_req = v.m1_req; m1_we = v.we; m1_adr = v.m1_adr; m1_wdata = ~v.wdata;
        eadr  = exp_m1 ? v.m1_adr : v.m0_adr;
        ewd   = exp_m1 ? ~v.wdata : v.wdata;
        field = eadr[31:28];
        esel  = (field >= 4'd1 && field <= 4'd3) ? (3'b001 << (field - 4'd1)) : 3'b000;
        s_ack = 3'b000; done = 1'b0; cyc = 0; acc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) gnt1 = grant;
            if (m0_ack || m1_ack) begin
                done = 1'b1; lat = cyc; got_m1 = m1_ack;
                err = m1_ack ? m1_err : m0_err;
                rd  = m1_ack ? m1_rdata : m0_rdata;
                if (m0_ack && m1_ack) bad = 1'b1;
                if (m1_ack && (m0_err || m0_rdata != 32'h0)) bad = 1'b1;
                if (m0_ack && (m1_err || m1_rdata != 32'h0)) bad = 1'b1;
                s_ack = 3'b000; m0_req = 1'b0; m1_req = 1'b0;
            end else begin
                if (m0_err || m1_err || m0_rdata != 32'h0 || m1_rdata != 32'h0) bad = 1'b1;
                if (s_sel != 3'b000) begin
                    acc++;
                    if (s_sel != esel || s_adr != eadr || s_we != v.we || s_wdata != ewd) bad = 1'b1;
                    rdv = {$urandom, $urandom, $urandom};
                    s_rdata = {rdv, ~rdv, rdv ^ 32'h1234_5678};
                    if (acc == v.ack_at) begin
                        for (int i = 0; i < 3; i++) if (s_sel[i]) s_rdata[32*i +: 32] = v.rdata;
                        s_ack = s_sel;
                    end else begin
                        s_ack = v.spur ? ~s_sel : 3'b000;
                    end
                end else begin
                    s_ack = 3'b000;
                end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0; s_ack = 3'b000;
        @(negedge clk);
        if (m0_ack || m1_ack || grant != 2'b00 || s_sel != 3'b000) bad = 1'b1;
    endtask

    task automatic do_txn(input string name, input vec_t v, input bit e_m1, input int e_lat,
                          input bit e_err, input logic [31:0] e_rd);
        bit got_m1, err, bad;
        int lat;
        logic [31:0] rd;
        logic [1:0] gnt1;
        run_txn(v, e_m1, got_m1, lat, err, rd, gnt1, bad);
        check($sformatf("%s_grant", name), 32'(gnt1), e_m1 ? 32'd2 : 32'd1);
        check($sformatf("%s_ack_owner", name), 32'(got_m1), 32'(e_m1));
        check($sformatf("%s_latency", name), 32'(lat), 32'(e_lat));
        check($sformatf("%s_err", name), 32'(err), 32'(e_err));
        check($sformatf("%s_rdata", name), rd, e_rd);
        check($sformatf("%s_protocol", name), 32'(bad), 32'd0);
    endtask

    initial begin
        vec_t tbl[11];
        vec_t v;
        bit m_m1, m_err, ack_seen;
        int m_lat;
        logic [31:0] m_rd;

        tbl[0]  = mk(1, 1, 32'h1000_0004, 32'h2000_0008, 0, 32'h0, 1, 0, 32'h1111_0000, 0, 2, 0, 32'h1111_0000);
        tbl[1]  = mk(1, 1, 32'h1000_0004, 32'h2000_0008, 0, 32'h0, 1, 0, 32'h2222_0000, 1, 2, 0, 32'h2222_0000);
        tbl[2]  = mk(1, 1, 32'h1000_0004, 32'h2000_0008, 1, 32'hA5A5_0002, 1, 0, 32'h3333_0000, 0, 2, 0, 32'h3333_0000);
        tbl[3]  = mk(1, 0, 32'h1000_0004, 32'h0, 0, 32'h0, 1, 0, 32'hCAFE_0001, 0, 2, 0, 32'hCAFE_0001);
        tbl[4]  = mk(0, 1, 32'h0, 32'h5000_0000, 1, 32'hDEAD_BEEF, 1, 0, 32'h4444_0000, 1, 1, 1, 32'h0);
        tbl[5]  = mk(1, 0, 32'h3000_0010, 32'h0, 0, 32'h0, 0, 0, 32'h5555_0000, 0, 17, 1, 32'h0);
        tbl[6]  = mk(0, 1, 32'h0, 32'h3000_0010, 0, 32'h0, 16, 0, 32'hABCD_0016, 1, 17, 0, 32'hABCD_0016);
        tbl[7]  = mk(1, 0, 32'h1000_0000, 32'h0, 0, 32'h0, 3, 1, 32'h5A5A_0007, 0, 4, 0, 32'h5A5A_0007);
        tbl[8]  = mk(1, 0, 32'h0000_0100, 32'h0, 1, 32'h0BAD_0008, 1, 0, 32'h6666_0000, 0, 1, 1, 32'h0);
        tbl[9]  = mk(1, 1, 32'hF000_0000, 32'h2000_0000, 0, 32'h0, 2, 1, 32'h7777_0009, 1, 3, 0, 32'h7777_0009);
        tbl[10] = mk(1, 1, 32'hF000_0000, 32'h2000_0000, 0, 32'h0, 2, 0, 32'h8888_000A, 0, 1, 1, 32'h0);

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(|{m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
                                     s_sel, s_we, s_adr, s_wdata, grant}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            model(tbl[i], m_m1, m_lat, m_err, m_rd);
            do_txn($sformatf("vec%0d", i), tbl[i], tbl[i].exp_m1, tbl[i].exp_lat,
                   tbl[i].exp_err, tbl[i].exp_rdata);
        end

        // Reset mid-transfer while the pointer favours m1, then contend.
        v = mk(1, 0, 32'h1000_0000, 32'h0, 0, 32'h0, 1, 0, 32'h1357_0000, 0, 2, 0, 32'h1357_0000);
        model(v, m_m1, m_lat, m_err, m_rd);
        do_txn("pre_rst", v, 1'b0, 2, 1'b0, 32'h1357_0000);
        m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h2000_0040; m0_wdata = 32'h0F0F_0F0F;
        repeat (3) @(negedge clk);
        check("rst_mid_sel", 32'(s_sel), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'(|{m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
                                       s_sel, s_we, s_adr, s_wdata, grant}), 32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_prio_m1 = 1'b0;
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m0_ack || m1_ack || grant != 2'b00) ack_seen = 1'b1;
        end
        check("rst_no_ack", 32'(ack_seen), 32'd0);
        v = mk(1, 1, 32'h3000_0000, 32'h3000_0004, 0, 32'h0, 2, 0, 32'h2468_0000, 0, 3, 0, 32'h2468_0000);
        model(v, m_m1, m_lat, m_err, m_rd);
        do_txn("post_rst", v, 1'b0, 3, 1'b0, 32'h2468_0000);

        // Random transfers against the model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            v.m0_req = r[0]; v.m1_req = r[1];
            v.m0_adr = {4'($urandom_range(0, 5)), 28'($urandom)};
            v.m1_adr = {4'($urandom_range(0, 5)), 28'($urandom)};
            v.we = 1'($urandom); v.wdata = $urandom; v.spur = 1'($urandom);
            v.rdata = $urandom;
            if ($urandom_range(0, 3) != 0) v.ack_at = $urandom_range(1, 4);
            else v.ack_at = $urandom_range(0, TO + 3);
            model(v, m_m1, m_lat, m_err, m_rd);
            do_txn($sformatf("rnd%0d", i), v, m_m1, m_lat, m_err, m_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
